nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 152 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple slice (add_by_one) reused once per nibble
// to form {cout,sum} = a + b + cin, plus a two's-complement overflow flag.

module add_by_one (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [1:0]             dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      sl_a, sl_b, sl_s;
  logic            sl_co;
  logic            last_nibble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_nibble) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The slice always looks at the nibble selected by idx; only RUN commits it.
  always_comb begin
    sl_a        = a_q[{idx_q, 2'b00} +: 4];
    sl_b        = b_q[{idx_q, 2'b00} +: 4];
    last_nibble = (idx_q == IW'(NIBBLES - 1));
  end

  add_by_one u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (c_q),
    .s    (sl_s),
    .cout (sl_co)
  );

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    idx_d  = idx_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          c_d    = cin;
          idx_d  = '0;
          sum_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = sl_s;
        c_d   = sl_co;
        idx_d = idx_q + IW'(1);
        if (last_nibble) begin
          cout_d = sl_co;
          // sl_s[3] is the final sum MSB being written on this edge.
          ovf_d  = (a_q[W-1] == b_q[W-1]) && (sl_s[3] != a_q[W-1]);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed corner cases on a 4-nibble instance and
// random operand sets on 2-, 4- and 8-nibble instances against an arithmetic model.

module tb_nibble_serial_adder;
  logic        clk;
  logic        rst;
  logic        start2, start4, start8;
  logic [31:0] a_in, b_in;
  logic        cin_in;

  logic        busy2, done2, cout2, ovf2;
  logic        busy4, done4, cout4, ovf4;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum2;
  logic [15:0] sum4;
  logic [31:0] sum8;
  logic [1:0]  dbg2, dbg4, dbg8;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [33:0] exp_q[$];

  nibble_serial_adder #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2), .dbg_state(dbg2));

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .dbg_state(dbg4));

  nibble_serial_adder #(.NIBBLES(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a_in), .b(b_in), .cin(cin_in),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .dbg_state(dbg8));

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit addition; overflow when like-signed operands give an unlike-signed sum.
  function automatic logic [33:0] model(input int n, input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci);
    int          w;
    logic [31:0] mask;
    logic [32:0] full;
    logic [31:0] s;
    logic        co, ov;
    w    = 4 * n;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full = {1'b0, av & mask} + {1'b0, bv & mask} + {32'h0, ci};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s};
  endfunction

  function automatic logic get_busy(input int n);
    case (n) 2: return busy2; 4: return busy4; default: return busy8; endcase
  endfunction
  function automatic logic get_done(input int n);
    case (n) 2: return done2; 4: return done4; default: return done8; endcase
  endfunction
  function automatic logic [33:0] get_res(input int n);
    case (n)
      2:       return {ovf2, cout2, 24'h0, sum2};
      4:       return {ovf4, cout4, 16'h0, sum4};
      default: return {ovf8, cout8, sum8};
    endcase
  endfunction

  task automatic set_start(input int n, input logic v);
    case (n) 2: start2 = v; 4: start4 = v; default: start8 = v; endcase
  endtask

  task automatic check_res(input string tag, input int n, input logic [33:0] exp);
    logic [33:0] obs;
    obs = get_res(n);
    check({tag, ".sum"},  {32'h0, obs[31:0]}, {32'h0, exp[31:0]});
    check({tag, ".cout"}, {63'h0, obs[32]},   {63'h0, exp[32]});
    check({tag, ".ovf"},  {63'h0, obs[33]},   {63'h0, exp[33]});
  endtask

  // One addition: optional idle gap, one-cycle start, then wait for done (bounded).
  // With poke set, operands and start are scrambled while the operation is in flight.
  task automatic run_op(input int n, input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input int gap, input bit poke, input string tag);
    int   lat, busy_cnt;
    bit   overlap;
    logic [33:0] exp;
    repeat (gap) @(negedge clk);
    a_in = av; b_in = bv; cin_in = ci;
    set_start(n, 1'b1);
    exp_q.push_back(model(n, av, bv, ci));
    @(negedge clk);
    set_start(n, 1'b0);
    check({tag, ".busy_first"}, {63'h0, get_busy(n)}, 64'h1);
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!get_done(n) && lat < 40) begin
      if (get_busy(n)) busy_cnt++;
      if (poke) begin
        a_in   = $urandom;
        b_in   = $urandom;
        cin_in = 1'($urandom_range(0, 1));
        set_start(n, 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      lat++;
    end
    if (get_busy(n) && get_done(n)) overlap = 1;
    set_start(n, 1'b0);
    check({tag, ".latency"},  lat,      n);
    check({tag, ".busy_cnt"}, busy_cnt, n);
    check({tag, ".overlap"},  {63'h0, overlap}, 64'h0);
    exp = exp_q.pop_front();
    check_res(tag, n, exp);
    @(negedge clk);
    check({tag, ".idle_after"}, {62'h0, get_busy(n), get_done(n)}, 64'h0);
  endtask

  initial begin
    int          last_t, pulses, nd;
    logic [33:0] e;
    rst = 1'b1; start2 = 0; start4 = 0; start8 = 0;
    a_in = '0; b_in = '0; cin_in = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst4", {30'h0, busy4, done4, cout4, ovf4, sum4}, 64'h0);
    check("rst2", {54'h0, busy2, done2, ovf2, cout2, sum2}, 64'h0);
    check("rst8", {28'h0, busy8, done8, ovf8, cout8, sum8}, 64'h0);

    // First start on the first edge with rst low
    rst = 1'b0;
    run_op(4, 32'h1234, 32'h4321, 1'b0, 0, 0, "basic");
    check("basic.sum_const", {48'h0, sum4}, 64'h5555);
    run_op(4, 32'hFFFF, 32'h0000, 1'b1, 1, 0, "ripple");
    check("ripple.const", {62'h0, cout4, ovf4}, 64'h2);
    run_op(4, 32'h7FFF, 32'h0001, 1'b0, 0, 0, "pos_ovf");
    check("pos_ovf.const", {46'h0, cout4, ovf4, sum4}, {46'h0, 2'b01, 16'h8000});
    run_op(4, 32'h8000, 32'h8000, 1'b0, 2, 0, "neg_ovf");
    check("neg_ovf.const", {46'h0, cout4, ovf4, sum4}, {46'h0, 2'b11, 16'h0000});

    // Ignored start pulses and operand changes during RUN
    run_op(4, 32'hABCD, 32'h1234, 1'b1, 0, 1, "poke");

    // start held high: one result every NIBBLES+2 cycles
    a_in = 32'h9F3C; b_in = 32'h60C4; cin_in = 1'b1;
    e = model(4, 32'h9F3C, 32'h60C4, 1'b1);
    start4 = 1'b1;
    last_t = -1; pulses = 0;
    for (int i = 0; i < 60 && pulses < 4; i++) begin
      @(negedge clk);
      if (done4) begin
        if (last_t >= 0) check("held.period", cyc - last_t, 6);
        check_res("held", 4, e);
        last_t = cyc;
        pulses++;
      end
    end
    check("held.pulses", pulses, 4);
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // Reset on the second RUN cycle aborts without a done pulse
    a_in = 32'h1111; b_in = 32'h2222; cin_in = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check("abort.busy_before", {63'h0, busy4}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.outputs", {30'h0, busy4, done4, cout4, ovf4, sum4}, 64'h0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4 || busy4) nd++;
      @(negedge clk);
    end
    check("abort.no_done", nd, 0);
    run_op(4, 32'hC0DE, 32'h3F21, 1'b1, 0, 0, "after_abort");

    // Random operand sets on each width
    for (int k = 0; k < 1000; k++)
      run_op(4, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), "rnd4");
    for (int k = 0; k < 1000; k++)
      run_op(2, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), "rnd2");
    for (int k = 0; k < 1000; k++)
      run_op(8, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), "rnd8");

    check("scoreboard.empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
